dist_ram_mp: RTL and testbench

Multi-read-port distributed RAM with byte-lane writes, a self-clearing sweep engine and an optional registered read stage. It is the next-generation register-file storage primitive for the VEGETA vTPU datapath: one write port feeds NUM_RD independent read ports, so the PE array and the writeback path can read operand rows in parallel. The clear engine guarantees known-zero contents after reset or on demand, without a reset net on the storage array.

---
 rtl/vTPU_pack.sv | 28 ++
 rtl/dist_ram_rd_port.sv | 60 ++++++
 rtl/dist_ram_mp.sv | 107 ++++++++++
 tb/tb_dist_ram_mp.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vTPU_pack.sv
// Shared definitions for the dist_ram_mp register-file storage: FSM state
// type, byte width and the byte-lane merge used by the write and bypass paths.
package vTPU_pack;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int BYTE_W     = 8;
    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dist_ram_rd_port.sv
// One read port: range check, zero-forcing while the array is swept, optional
// write-first bypass (DIST_RAM_WR_BYPASS_EN) and optional output register.
module dist_ram_rd_port
    import vTPU_pack::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_DEPTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int READ_REG      = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      busy,
    input  logic [ADDRESS_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]     mem_word,
    input  logic                      wr_ok,
    input  logic [ADDRESS_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic [DATA_WIDTH-1:0]     data
);

    logic                  addr_bad;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] word_gated;

    assign addr_bad = int'(addr) >= DATA_DEPTH;

`ifdef DIST_RAM_WR_BYPASS_EN
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        word = mem_word;
        if (wr_ok && (addr == wr_addr)) begin
            word = DATA_WIDTH'(be_merge(MAX_DATA_W'(mem_word), MAX_DATA_W'(wr_data),
                                        MAX_BE_W'(wr_be)));
        end
    end
`else
    assign word = mem_word;
    logic unused_wr;
    assign unused_wr = ^{wr_ok, wr_addr, wr_be, wr_data};
`endif

    // Sweep zero-forcing sits ahead of the optional register.
    assign word_gated = (busy || addr_bad) ? '0 : word;

    generate
        if (READ_REG != 0) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) data <= '0;
                else        data <= word_gated;
            end
        end else begin : g_comb
            assign data = word_gated;
            logic unused_clk;
            assign unused_clk = ^{clk, rst_n};
        end
    endgenerate

endmodule

// File: rtl/dist_ram_mp.sv
// Multi-read-port distributed RAM with byte-lane writes and a self-clearing
// sweep engine; DIST_RAM_WR_BYPASS_EN selects write-first reads.
module dist_ram_mp
    import vTPU_pack::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_DEPTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_RD        = 2,
    parameter int READ_REG      = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear_req,
    output logic                              busy,
    input  logic                              wr_en,
    input  logic [ADDRESS_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH/8-1:0]           wr_be,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              wr_err,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]      rd_data
);

    localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    rf_state_e                 state;
    rf_state_e                 state_next;
    logic [ADDRESS_WIDTH-1:0]  clr_ptr;
    logic                      clr_last;
    logic                      wr_req;
    logic                      wr_bad;
    logic                      wr_ok;
    logic                      err_next;
    logic [DATA_WIDTH-1:0]     wr_word;
    logic [DATA_WIDTH-1:0]     ram [DATA_DEPTH];

    assign clr_last = clr_ptr == ADDRESS_WIDTH'(DATA_DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == RF_CLEAR) clr_ptr <= clr_last ? '0 : clr_ptr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RF_IDLE:  if (clear_req) state_next = RF_CLEAR;
            RF_CLEAR: if (clr_last)  state_next = RF_IDLE;
            default:  state_next = RF_CLEAR;
        endcase
    end

    always_comb begin
        busy = (state == RF_CLEAR);
    end

    // A write with no lanes enabled is a silent no-op, never an error.
    assign wr_req   = wr_en && (|wr_be);
    assign wr_bad   = int'(wr_addr) >= DATA_DEPTH;
    assign wr_ok    = wr_req && !busy && !clear_req && !wr_bad;
    assign err_next = wr_req && (busy || clear_req || wr_bad);
    assign wr_word  = DATA_WIDTH'(be_merge(MAX_DATA_W'(ram[IDX_W'(wr_addr)]),
                                           MAX_DATA_W'(wr_data), MAX_BE_W'(wr_be)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_err <= 1'b0;
        else        wr_err <= err_next;
    end

    // NOTE: the storage array has no reset; the clear sweep defines its contents.
    always_ff @(posedge clk) begin
        if (busy)       ram[IDX_W'(clr_ptr)] <= '0;
        else if (wr_ok) ram[IDX_W'(wr_addr)] <= wr_word;
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [DATA_WIDTH-1:0] mem_word;
            assign mem_word = ram[IDX_W'(rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH])];

            dist_ram_rd_port #(
                .DATA_WIDTH    (DATA_WIDTH),
                .DATA_DEPTH    (DATA_DEPTH),
                .ADDRESS_WIDTH (ADDRESS_WIDTH),
                .READ_REG      (READ_REG)
            ) u_rd_port (
                .clk      (clk),
                .rst_n    (rst_n),
                .busy     (busy),
                .addr     (rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
                .mem_word (mem_word),
                .wr_ok    (wr_ok),
                .wr_addr  (wr_addr),
                .wr_be    (wr_be),
                .wr_data  (wr_data),
                .data     (rd_data[p*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dist_ram_mp.sv
// Bench for dist_ram_mp: a combinational-read and a registered-read instance
// share stimulus and are compared against an array-based reference model.
module tb_dist_ram_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 6;
    localparam int NR    = 2;
    localparam int BEW   = DW / 8;
`ifdef DIST_RAM_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clear_req = 1'b0;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [BEW-1:0] wr_be = '0;
    logic [DW-1:0]  wr_data = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic           busy_c, wr_err_c, busy_r, wr_err_r;
    logic [NR*DW-1:0] rd_data_c, rd_data_r;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left;
    int            m_idx;
    logic          m_err;
    logic [DW-1:0] m_rreg [NR];

    always #5 clk = ~clk;

    dist_ram_mp #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ADDRESS_WIDTH(AW),
                  .NUM_RD(NR), .READ_REG(0)) u_dut_comb (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .wr_err(wr_err_c), .rd_addr(rd_addr), .rd_data(rd_data_c));

    dist_ram_mp #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ADDRESS_WIDTH(AW),
                  .NUM_RD(NR), .READ_REG(1)) u_dut_reg (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_r),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .wr_err(wr_err_r), .rd_addr(rd_addr), .rd_data(rd_data_r));

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < BEW; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic bit model_wr_ok();
        return wr_en && (wr_be != '0) && (m_left == 0) && !clear_req && (int'(wr_addr) < DEPTH);
    endfunction

    function automatic logic [DW-1:0] model_read(input int a);
        if (m_left > 0) return '0;
        if (a >= DEPTH) return '0;
        if (BYPASS && model_wr_ok() && a == int'(wr_addr)) return merge(m_mem[a], wr_data, wr_be);
        return m_mem[a];
    endfunction

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        clear_req = 1'b0;
        wr_en     = 1'b0;
        wr_be     = '0;
    endtask

    // One clock: check combinational reads, advance the model at the edge,
    // then check busy, wr_err and registered reads.
    task automatic step();
        logic [DW-1:0] exp_v;
        logic [DW-1:0] nxt [NR];
        bit ok, err;
        #1;
        ok  = model_wr_ok();
        err = wr_en && (wr_be != '0) && !ok;
        for (int p = 0; p < NR; p++) begin
            exp_v  = model_read(int'(rd_addr[p*AW +: AW]));
            nxt[p] = exp_v;
            checks++;
            if (rd_data_c[p*DW +: DW] !== exp_v) begin
                errors++;
                $display("FAIL %s comb_rd port %0d addr %0d: got %h expected %h", phase, p,
                         rd_addr[p*AW +: AW], rd_data_c[p*DW +: DW], exp_v);
            end
        end
        @(posedge clk);
        if (m_left > 0) begin
            m_mem[m_idx] = '0;
            m_idx++;
            m_left--;
        end else begin
            if (clear_req) begin
                m_left = DEPTH;
                m_idx  = 0;
            end
            if (ok) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
        end
        m_err  = err;
        m_rreg = nxt;
        #1;
        checks++;
        if (busy_c !== (m_left > 0) || busy_r !== (m_left > 0)) begin
            errors++;
            $display("FAIL %s busy: got %b/%b expected %b", phase, busy_c, busy_r, m_left > 0);
        end
        checks++;
        if (wr_err_c !== m_err || wr_err_r !== m_err) begin
            errors++;
            $display("FAIL %s wr_err: got %b/%b expected %b", phase, wr_err_c, wr_err_r, m_err);
        end
        for (int p = 0; p < NR; p++) begin
            checks++;
            if (rd_data_r[p*DW +: DW] !== m_rreg[p]) begin
                errors++;
                $display("FAIL %s reg_rd port %0d: got %h expected %h", phase, p,
                         rd_data_r[p*DW +: DW], m_rreg[p]);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        wr_be   = be;
        step();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n  = 1'b0;
        m_left = DEPTH;
        m_idx  = 0;
        m_err  = 1'b0;
        for (int p = 0; p < NR; p++) m_rreg[p] = '0;
        #1;
        checks++;
        if (busy_c !== 1'b1 || busy_r !== 1'b1 || wr_err_c !== 1'b0 || wr_err_r !== 1'b0
            || rd_data_r !== '0) begin
            errors++;
            $display("FAIL %s reset_values: got busy %b/%b err %b/%b rd_r %h expected 1/1 0/0 0",
                     phase, busy_c, busy_r, wr_err_c, wr_err_r, rd_data_r);
        end
        #1;
        rst_n = 1'b1;
    endtask

    // Runs until busy drops and returns the number of clocks it stayed high.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy_c === 1'b1 && n < 100) begin
            set_rd(0, $urandom_range(0, DEPTH + 3));
            set_rd(1, $urandom_range(0, DEPTH + 3));
            step();
            n++;
        end
    endtask

    task automatic scan_zero();
        for (int a = 0; a < DEPTH + 4; a++) begin
            set_rd(0, a);
            set_rd(1, (DEPTH + 3) - a);
            #1;
            checks++;
            if (rd_data_c !== '0) begin
                errors++;
                $display("FAIL %s zero_scan addr %0d: got %h expected 0", phase, a, rd_data_c);
            end
            step();
        end
    endtask

    task automatic test_reset();
        int n;
        phase = "reset";
        do_reset();
        wait_idle(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", phase, n, DEPTH);
        end
        scan_zero();
    endtask

    task automatic test_byte_lanes();
        phase = "byte_lanes";
        do_write(5, 32'hAABBCCDD, 4'hF);
        do_write(5, 32'h11223344, 4'h2);
        do_write(5, 32'hFFFFFFFF, 4'h0);
        checks++;
        if (wr_err_c !== 1'b0) begin
            errors++;
            $display("FAIL %s zero_be_err: got %b expected 0", phase, wr_err_c);
        end
        set_rd(0, 5);
        set_rd(1, 5);
        #1;
        for (int p = 0; p < NR; p++) begin
            checks++;
            if (rd_data_c[p*DW +: DW] !== 32'hAABB33DD) begin
                errors++;
                $display("FAIL %s merged port %0d: got %h expected aabb33dd", phase, p,
                         rd_data_c[p*DW +: DW]);
            end
        end
        step();
    endtask

    task automatic test_wr_err();
        int n;
        phase = "wr_err";
        do_write(40, $urandom, 4'hF);
        checks++;
        if (wr_err_c !== 1'b1) begin
            errors++;
            $display("FAIL %s oob_err: got %b expected 1", phase, wr_err_c);
        end
        step();
        checks++;
        if (wr_err_c !== 1'b0) begin
            errors++;
            $display("FAIL %s err_pulse_width: got %b expected 0", phase, wr_err_c);
        end
        // clear_req and a write together: clear wins
        clear_req = 1'b1;
        #1;
        checks++;
        if (busy_c !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_before_clear: got %b expected 0", phase, busy_c);
        end
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = $urandom; wr_be = 4'hF;
        step();
        idle();
        checks++;
        if (wr_err_c !== 1'b1 || busy_c !== 1'b1) begin
            errors++;
            $display("FAIL %s clear_write: got err %b busy %b expected 1 1", phase, wr_err_c, busy_c);
        end
        repeat (20) step();
        // entry 0 is already swept, so a leaked write would survive
        do_write(0, 32'hDEADBEEF, 4'hF);
        checks++;
        if (wr_err_c !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_write_err: got %b expected 1", phase, wr_err_c);
        end
        wait_idle(n);
        set_rd(0, 0);
        set_rd(1, 9);
        #1;
        checks++;
        if (rd_data_c !== '0) begin
            errors++;
            $display("FAIL %s dropped_write_mem: got %h expected 0", phase, rd_data_c);
        end
        step();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] a, b, c, exp1;
        phase = "same_cycle";
        a = $urandom; b = $urandom; c = ~b;
        do_write(5, a, 4'hF);
        do_write(7, b, 4'hF);
        set_rd(0, 5);
        set_rd(1, 7);
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = c; wr_be = 4'b0101;
        #1;
        exp1 = BYPASS ? merge(b, c, 4'b0101) : b;
        checks++;
        if (rd_data_c[DW-1:0] !== a) begin
            errors++;
            $display("FAIL %s port0: got %h expected %h", phase, rd_data_c[DW-1:0], a);
        end
        checks++;
        if (rd_data_c[2*DW-1:DW] !== exp1) begin
            errors++;
            $display("FAIL %s port1: got %h expected %h", phase, rd_data_c[2*DW-1:DW], exp1);
        end
        step();
        idle();
        #1;
        checks++;
        if (rd_data_c[2*DW-1:DW] !== merge(b, c, 4'b0101)) begin
            errors++;
            $display("FAIL %s after_write: got %h expected %h", phase, rd_data_c[2*DW-1:DW],
                     merge(b, c, 4'b0101));
        end
        step();
    endtask

    task automatic test_read_reg();
        logic [DW-1:0] a, b;
        phase = "read_reg";
        a = $urandom; b = a ^ 32'h5A5A_0F0F;
        do_write(3, a, 4'hF);
        do_write(4, b, 4'hF);
        set_rd(0, 3);
        step();
        checks++;
        if (rd_data_r[DW-1:0] !== a) begin
            errors++;
            $display("FAIL %s addr3: got %h expected %h", phase, rd_data_r[DW-1:0], a);
        end
        set_rd(0, 4);
        #1;
        checks++;
        if (rd_data_r[DW-1:0] !== a || rd_data_c[DW-1:0] !== b) begin
            errors++;
            $display("FAIL %s latency: got reg %h comb %h expected %h %h", phase,
                     rd_data_r[DW-1:0], rd_data_c[DW-1:0], a, b);
        end
        step();
        checks++;
        if (rd_data_r[DW-1:0] !== b) begin
            errors++;
            $display("FAIL %s addr4: got %h expected %h", phase, rd_data_r[DW-1:0], b);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        phase = "mid_sweep_reset";
        for (int a = 0; a < DEPTH; a++) do_write(a, $urandom | 32'h1, 4'hF);
        clear_req = 1'b1;
        step();
        idle();
        repeat (10) step();
        do_reset();
        wait_idle(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", phase, n, DEPTH);
        end
        scan_zero();
    endtask

    task automatic test_random();
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            clear_req = ($urandom_range(0, 63) == 0);
            wr_en     = $urandom_range(0, 1) == 1;
            wr_addr   = AW'($urandom_range(0, 39));
            wr_be     = BEW'($urandom);
            wr_data   = $urandom;
            for (int p = 0; p < NR; p++) begin
                if ($urandom_range(0, 3) == 0) set_rd(p, int'(wr_addr));
                else                           set_rd(p, $urandom_range(0, 35));
            end
            step();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_byte_lanes();
        test_wr_err();
        test_bypass();
        test_read_reg();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
